// File: rtl/bitwise_fold_unit.sv
// bitwise_fold_unit: folds a packet of (a OP b) beats into one registered result.
// Optional out_zero flag is enabled by defining BITWISE_FOLD_ZERO_FLAG_EN.
`default_nettype none

module bitwise_fold_unit #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNTW-1:0]  out_beats,
    output logic             out_valid,
    input  logic             out_ready
`ifdef BITWISE_FOLD_ZERO_FLAG_EN
    ,
    output logic             out_zero
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPEN = 2'd1,
        S_FULL = 2'd2
    } state_t;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    state_t           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [CNTW-1:0]  cnt_q;
    logic [1:0]       op_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic             accept;
    logic [1:0]       beat_op;
    logic [WIDTH-1:0] beat_r;
    logic [WIDTH-1:0] acc_d;
    logic [CNTW-1:0]  cnt_d;

    function automatic logic [WIDTH-1:0] apply_op(input logic [1:0]       op,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] res;
        case (op)
            OP_AND:  res = x & y;
            OP_OR:   res = x | y;
            OP_XOR:  res = x ^ y;
            default: res = ~(x & y);
        endcase
        return res;
    endfunction

    // Beats after the first use the latched packet op for both the per-beat
    // value and the fold; in_op only matters on the opening beat.
    always_comb begin
        accept  = in_valid && in_ready_q;
        beat_op = (state_q == S_IDLE) ? in_op : op_q;
        beat_r  = apply_op(beat_op, in_a, in_b);
        acc_d   = (state_q == S_IDLE) ? beat_r : apply_op(op_q, acc_q, beat_r);
        if (state_q == S_IDLE) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

`ifdef BITWISE_FOLD_ZERO_FLAG_EN
    logic zero_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            op_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef BITWISE_FOLD_ZERO_FLAG_EN
            zero_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE, S_OPEN: begin
                    if (accept) begin
                        op_q  <= beat_op;
                        acc_q <= acc_d;
                        cnt_q <= cnt_d;
                        if (in_last) begin
                            state_q     <= S_FULL;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
`ifdef BITWISE_FOLD_ZERO_FLAG_EN
                            zero_q      <= (acc_d == '0);
`endif
                        end else begin
                            state_q <= S_OPEN;
                        end
                    end
                end
                S_FULL: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
`ifdef BITWISE_FOLD_ZERO_FLAG_EN
                        zero_q      <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
`ifdef BITWISE_FOLD_ZERO_FLAG_EN
                    zero_q      <= 1'b0;
`endif
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign out_beats = cnt_q;
`ifdef BITWISE_FOLD_ZERO_FLAG_EN
    assign out_zero  = zero_q;
`endif

endmodule

`default_nettype wire
